// File: rtl/instr_fetcher_pkg.sv
// Shared opcode constants, fetch state encoding and immediate helpers
// for the instruction fetcher. Optional feature macro: FETCH_BTFN_EN.
package instr_fetcher_pkg;

    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] B_TYPE = 7'b1100011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        STALL = 2'd3
    } fetch_state_e;

    function automatic logic [31:0] imm_j(input logic [31:0] w);
        return {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] w);
        return {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/instr_fetcher_predecode.sv
// Static next-PC predecode for a fetched word.
// FETCH_BTFN_EN enables backward-taken branch prediction.
module fetch_predecode
    import instr_fetcher_pkg::*;
(
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output logic [31:0] next_pc_o,
    output logic        pred_taken_o,
    output logic        is_jalr_o
);

    logic [6:0] op;
    assign op = instr_i[6:0];

    always_comb begin
        next_pc_o    = pc_i + 32'd4;
        pred_taken_o = 1'b0;
        is_jalr_o    = 1'b0;
        unique case (1'b1)
            (op == JAL): begin
                next_pc_o    = pc_i + imm_j(instr_i);
                pred_taken_o = 1'b1;
            end
            (op == JALR): begin
                is_jalr_o = 1'b1;
            end
            (op == B_TYPE): begin
`ifdef FETCH_BTFN_EN
                if (instr_i[31]) begin
                    next_pc_o    = pc_i + imm_b(instr_i);
                    pred_taken_o = 1'b1;
                end
`else
                pred_taken_o = 1'b0;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/instr_fetcher.sv
// Fetch stage: owns the PC, one outstanding icache request, one-entry
// instruction buffer to the decoder. Optional macro: FETCH_BTFN_EN.
module instr_fetcher
    import instr_fetcher_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    output logic        icache_req_valid,
    output logic [31:0] icache_req_addr,
    input  logic        icache_req_ready,
    input  logic        icache_resp_valid,
    input  logic [31:0] icache_resp_data,
    output logic        instr_valid,
    output logic [31:0] instr_out,
    output logic [31:0] instr_addr_out,
    output logic        pred_taken_out,
    output logic [31:0] pred_pc_out,
    input  logic        instr_issued,
    input  logic        flush,
    input  logic [31:0] flush_pc
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  next_pc_q, next_pc_d;
    logic         discard_q, discard_d;
    logic         jalr_stall_q, jalr_stall_d;
    logic         instr_valid_q, instr_valid_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  instr_addr_q, instr_addr_d;
    logic         pred_taken_q, pred_taken_d;
    logic [31:0]  pred_pc_q, pred_pc_d;

    logic [31:0]  pd_next_pc;
    logic         pd_taken;
    logic         pd_is_jalr;

    fetch_predecode u_predecode (
        .instr_i      (icache_resp_data),
        .pc_i         (pc_q),
        .next_pc_o    (pd_next_pc),
        .pred_taken_o (pd_taken),
        .is_jalr_o    (pd_is_jalr)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        next_pc_d     = next_pc_q;
        discard_d     = discard_q;
        jalr_stall_d  = jalr_stall_q;
        instr_valid_d = instr_valid_q;
        instr_d       = instr_q;
        instr_addr_d  = instr_addr_q;
        pred_taken_d  = pred_taken_q;
        pred_pc_d     = pred_pc_q;
        if (flush) begin
            pc_d          = flush_pc;
            instr_valid_d = 1'b0;
            pred_taken_d  = 1'b0;
            pred_pc_d     = 32'd0;
            jalr_stall_d  = 1'b0;
            // An accepted or in-flight request belongs to the old path.
            unique case (state_q)
                IDLE: begin
                    state_d   = icache_req_ready ? WAIT : IDLE;
                    discard_d = icache_req_ready;
                end
                WAIT: begin
                    state_d   = icache_resp_valid ? IDLE : WAIT;
                    discard_d = !icache_resp_valid;
                end
                default: state_d = IDLE;
            endcase
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (icache_req_ready) state_d = WAIT;
                end
                WAIT: begin
                    if (icache_resp_valid && discard_q) begin
                        discard_d = 1'b0;
                        state_d   = IDLE;
                    end else if (icache_resp_valid) begin
                        instr_d       = icache_resp_data;
                        instr_addr_d  = pc_q;
                        instr_valid_d = 1'b1;
                        pred_taken_d  = pd_taken;
                        pred_pc_d     = pd_next_pc;
                        next_pc_d     = pd_next_pc;
                        jalr_stall_d  = pd_is_jalr;
                        state_d       = HOLD;
                    end
                end
                HOLD: begin
                    if (instr_issued) begin
                        pc_d          = next_pc_q;
                        instr_valid_d = 1'b0;
                        state_d = jalr_stall_q ? STALL : IDLE;
                    end
                end
                STALL: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            next_pc_q     <= RESET_PC;
            discard_q     <= 1'b0;
            jalr_stall_q  <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_q       <= 32'd0;
            instr_addr_q  <= 32'd0;
            pred_taken_q  <= 1'b0;
            pred_pc_q     <= 32'd0;
        end else if (rdy) begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            next_pc_q     <= next_pc_d;
            discard_q     <= discard_d;
            jalr_stall_q  <= jalr_stall_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            instr_addr_q  <= instr_addr_d;
            pred_taken_q  <= pred_taken_d;
            pred_pc_q     <= pred_pc_d;
        end
    end

    assign icache_req_valid = rdy && !rst && (state_q == IDLE);
    assign icache_req_addr  = pc_q;
    assign instr_valid      = instr_valid_q;
    assign instr_out        = instr_q;
    assign instr_addr_out   = instr_addr_q;
    assign pred_taken_out   = pred_taken_q;
    assign pred_pc_out      = pred_pc_q;

endmodule

// File: tb/tb_instr_fetcher.sv
// Directed bench for instr_fetcher with a transaction-level reference
// model compared every cycle; honours FETCH_BTFN_EN.
module tb_instr_fetcher;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        req_ready, resp_valid, issued, flush;
    logic [31:0] resp_data, flush_pc;
    logic        icache_req_valid, instr_valid, pred_taken_out;
    logic [31:0] icache_req_addr, instr_out, instr_addr_out, pred_pc_out;

    int errs   = 0;
    int checks = 0;

    instr_fetcher #(.RESET_PC(32'h0)) dut (
        .clk               (clk),
        .rst               (rst),
        .rdy               (rdy),
        .icache_req_valid  (icache_req_valid),
        .icache_req_addr   (icache_req_addr),
        .icache_req_ready  (req_ready),
        .icache_resp_valid (resp_valid),
        .icache_resp_data  (resp_data),
        .instr_valid       (instr_valid),
        .instr_out         (instr_out),
        .instr_addr_out    (instr_addr_out),
        .pred_taken_out    (pred_taken_out),
        .pred_pc_out       (pred_pc_out),
        .instr_issued      (issued),
        .flush             (flush),
        .flush_pc          (flush_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: a request in flight, a word held for the decoder,
    // a pending drop of a stale word, and a JALR block.
    bit          m_init = 0;
    bit          m_out, m_drop, m_have, m_blocked, m_jalr;
    logic [31:0] m_pc, m_npc, m_instr, m_addr, m_ppc;
    bit          m_ptaken;

    function automatic logic [32:0] predict(input logic [31:0] w,
                                            input logic [31:0] pc);
        logic signed [20:0] j;
        logic signed [12:0] b;
        int off;
        j = {w[31], w[19:12], w[20], w[30:21], 1'b0};
        b = {w[31], w[7], w[30:25], w[11:8], 1'b0};
        if (w[6:0] == 7'h6F) begin
            off = j;
            return {1'b1, pc + off};
        end
`ifdef FETCH_BTFN_EN
        if (w[6:0] == 7'h63 && w[31]) begin
            off = b;
            return {1'b1, pc + off};
        end
`endif
        return {1'b0, pc + 32'd4};
    endfunction

    function automatic bit exp_req();
        return rdy && !rst && !m_out && !m_have && !m_blocked;
    endfunction

    always @(posedge clk) begin
        bit          acc;
        logic [32:0] p;
        acc = exp_req() && req_ready;
        if (rst) begin
            m_init = 1; m_out = 0; m_drop = 0; m_have = 0;
            m_blocked = 0; m_jalr = 0; m_pc = 0; m_npc = 0;
            m_instr = 0; m_addr = 0; m_ppc = 0; m_ptaken = 0;
        end else if (rdy && flush) begin
            m_pc = flush_pc; m_have = 0; m_ptaken = 0;
            m_ppc = 0; m_blocked = 0; m_jalr = 0;
            if (m_out) begin
                m_out  = !resp_valid;
                m_drop = !resp_valid;
            end else if (acc) begin
                m_out = 1; m_drop = 1;
            end
        end else if (rdy) begin
            if (acc) begin
                m_out = 1;
            end else if (m_out && resp_valid) begin
                m_out = 0;
                if (m_drop) m_drop = 0;
                else begin
                    p = predict(resp_data, m_pc);
                    m_have = 1; m_instr = resp_data; m_addr = m_pc;
                    m_ptaken = p[32]; m_ppc = p[31:0]; m_npc = p[31:0];
                    m_jalr = (resp_data[6:0] == 7'h67);
                end
            end else if (m_have && issued) begin
                m_have = 0; m_pc = m_npc; m_blocked = m_jalr;
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("req_valid", icache_req_valid, exp_req());
            chk("req_addr", icache_req_addr, m_pc);
            chk("instr_valid", instr_valid, m_have);
            chk("instr_out", instr_out, m_instr);
            chk("instr_addr", instr_addr_out, m_addr);
            chk("pred_taken", pred_taken_out, m_ptaken);
            chk("pred_pc", pred_pc_out, m_ppc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!icache_req_valid && n < 40) begin
            tick();
            n++;
        end
        chk("req_timeout", icache_req_valid, 1);
    endtask

    task automatic fetch(input logic [31:0] w, input int lat);
        wait_req();
        req_ready = 1;
        tick();
        req_ready = 0;
        repeat (lat - 1) tick();
        resp_valid = 1;
        resp_data  = w;
        tick();
        resp_valid = 0;
    endtask

    task automatic issue();
        issued = 1;
        tick();
        issued = 0;
    endtask

    task automatic do_flush(input logic [31:0] t);
        flush = 1;
        flush_pc = t;
        tick();
        flush = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; rdy = 1; req_ready = 0; resp_valid = 0;
        issued = 0; flush = 0; resp_data = 0; flush_pc = 0;
        tick();
        chk("rst_valid", instr_valid, 0);
        chk("rst_req", icache_req_valid, 0);
        chk("rst_addr", icache_req_addr, 32'h0);
        tick();
        rst = 0;

        fetch(32'h0000_0013, 1);
        chk("addi_valid", instr_valid, 1);
        chk("addi_addr", instr_addr_out, 32'h0);
        chk("addi_ppc", pred_pc_out, 32'h4);
        issue();
        chk("addi_next_v", icache_req_valid, 1);
        chk("addi_next_a", icache_req_addr, 32'h4);

        fetch(32'h0000_0013, 1);
        issue();
        fetch(32'h0100_006F, 2);
        chk("jal_taken", pred_taken_out, 1);
        chk("jal_ppc", pred_pc_out, 32'd24);
        issue();
        chk("jal_next", icache_req_addr, 32'd24);

        do_flush(32'h20);
        chk("fl_idle_a", icache_req_addr, 32'h20);
        fetch(32'hFE00_0EE3, 1);
`ifdef FETCH_BTFN_EN
        chk("beq_ppc", pred_pc_out, 32'h1C);
        chk("beq_taken", pred_taken_out, 1);
`else
        chk("beq_ppc", pred_pc_out, 32'h24);
        chk("beq_taken", pred_taken_out, 0);
`endif
        issue();

        do_flush(32'h40);
        fetch(32'h0000_8067, 1);
        chk("jalr_taken", pred_taken_out, 0);
        issue();
        repeat (10) begin
            chk("jalr_stall", icache_req_valid, 0);
            tick();
        end
        do_flush(32'h100);
        chk("stall_fl_v", icache_req_valid, 1);
        chk("stall_fl_a", icache_req_addr, 32'h100);

        req_ready = 1;
        tick();
        req_ready = 0;
        do_flush(32'h200);
        tick();
        resp_valid = 1;
        resp_data  = 32'h0000_0013;
        tick();
        resp_valid = 0;
        chk("wait_fl_iv", instr_valid, 0);
        chk("wait_fl_v", icache_req_valid, 1);
        chk("wait_fl_a", icache_req_addr, 32'h200);

        req_ready = 1;
        do_flush(32'h300);
        req_ready = 0;
        chk("acc_fl_v", icache_req_valid, 0);
        resp_valid = 1;
        resp_data  = 32'h0100_006F;
        tick();
        resp_valid = 0;
        chk("acc_fl_iv", instr_valid, 0);
        chk("acc_fl_a", icache_req_addr, 32'h300);

        req_ready = 1;
        tick();
        req_ready = 0;
        resp_valid = 1;
        do_flush(32'h400);
        resp_valid = 0;
        chk("rsp_fl_iv", instr_valid, 0);
        chk("rsp_fl_a", icache_req_addr, 32'h400);

        fetch(32'h0000_0013, 1);
        issued = 1;
        flush = 1;
        flush_pc = 32'h500;
        rdy = 0;
        repeat (3) begin
            tick();
            chk("frz_iv", instr_valid, 1);
            chk("frz_req", icache_req_valid, 0);
        end
        rdy = 1;
        tick();
        issued = 0;
        flush = 0;
        chk("hold_fl_iv", instr_valid, 0);
        chk("hold_fl_v", icache_req_valid, 1);
        chk("hold_fl_a", icache_req_addr, 32'h500);

        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetcher.md
Name: instr_fetcher

Overview:
- Front-end stage directly upstream of the decoder.
- Owns the PC and issues one instruction-word request at a time to the instruction cache.
- Buffers the returned word and presents it to the decoder with a valid/issued handshake.
- Applies static next-PC prediction, stalls on JALR, and redirects on a flush from the RoB.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
rdy  input  1  global ready; 0 freezes all state
icache_req_valid  output  1  fetch request valid
icache_req_addr  output  32  fetch address (word aligned)
icache_req_ready  input  1  icache accepts request this cycle
icache_resp_valid  input  1  returned word valid (one-cycle pulse)
icache_resp_data  input  32  returned instruction word
instr_valid  output  1  buffered instruction valid, to decoder
instr_out  output  32  buffered instruction word
instr_addr_out  output  32  PC of buffered instruction
pred_taken_out  output  1  fetcher predicted taken
pred_pc_out  output  32  predicted next PC
instr_issued  input  1  decoder consumed instr this cycle
flush  input  1  RoB mispredict/redirect
flush_pc  input  32  redirect target

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values: pc=RESET_PC, state=IDLE, discard=0; all outputs 0 except icache_req_addr=RESET_PC.
- rdy=0: no register updates, all inputs ignored, icache_req_valid forced 0.
- IDLE:
  - Drive icache_req_valid=1 and icache_req_addr=pc.
  - On icache_req_ready, go to WAIT.
- WAIT:
  - On icache_resp_valid with discard=0: latch the word into instr_out and pc into instr_addr_out, then go to HOLD.
  - instr_valid rises in the cycle after the response.
  - Predecode next PC:
    - JAL: pc+immJ, pred_taken=1.
    - JALR: set jalr_stall, pred_taken=0.
    - Anything else: pc+4, pred_taken=0.
    - B_TYPE: per the Optional Feature.
  - Store the result in pred_pc_out and the internal next_pc.
- HOLD:
  - instr_valid=1.
  - On instr_issued: pc<=next_pc; go to STALL if jalr_stall, else IDLE.
  - The next request is driven in the cycle after the issue.
- STALL: no requests; wait for flush.
- Flush, highest priority, any state:
  - pc<=flush_pc; instr_valid<=0; pred outputs cleared; jalr_stall<=0.
  - WAIT without a same-cycle response: stay WAIT with discard=1.
  - WAIT with a same-cycle response: drop it, go to IDLE.
  - IDLE with the request accepted the same cycle: go to WAIT with discard=1.
  - HOLD + instr_issued in the same cycle: flush wins, issue ignored, go to IDLE.
  - IDLE/STALL otherwise: go to IDLE.
- WAIT with discard=1: a response is dropped, discard<=0, go to IDLE.
- Flush while discard=1 and no response: pc updated, remain discarding.
- Exactly one outstanding request is allowed at any time.
- Arithmetic:
  - All PC sums are 32-bit modulo; wrap is silent.
  - Immediates are sign-extended to 32 bits.
- Unsupported encodings:
  - Compressed or unknown opcodes predict pc+4.
  - Illegal-instruction detection is downstream.

Optional Feature:
- FETCH_BTFN_EN defined: B_TYPE with negative immediate (bit31=1) predicts pc+immB with pred_taken=1; positive immediate predicts pc+4.
- Undefined: all B_TYPE predict pc+4 with pred_taken=0.

Decomposition:
- Shared defines header:
  - Existing opcode constants JAL, JALR, B_TYPE.
  - Fetch state encoding: IDLE=2'd0, WAIT=2'd1, HOLD=2'd2, STALL=2'd3.
- Sub-module fetch_predecode (combinational):
  - Inputs: instruction word and pc.
  - Outputs: next_pc, pred_taken, is_jalr.
  - Contains the immediate extraction and the FETCH_BTFN_EN logic.

Test Plan:
- Reset, then icache returns 32'h00000013 (ADDI) in the cycle after acceptance: instr_valid=1 one cycle after the response, instr_addr_out=0, pred_pc_out=4; after instr_issued, icache_req_addr=4 next cycle.
- Word 32'h0100006F (JAL +16) at pc=8: pred_taken_out=1, pred_pc_out=24, next request at 24.
- Word 32'hFE000EE3 (BEQ -4) at pc=0x20: with FETCH_BTFN_EN pred_pc_out=0x1C, taken=1; without it pred_pc_out=0x24, taken=0.
- JALR 32'h00008067 at pc=0x40: after issue no icache_req_valid for 10 cycles; flush with flush_pc=0x100 gives a request at 0x100 next cycle.
- Flush (flush_pc=0x200) while WAIT, response two cycles later: response dropped, instr_valid stays 0, then a request at 0x200.
- instr_issued, then flush the same cycle in HOLD with rdy toggled low for 3 cycles beforehand: state frozen while rdy=0; flush wins; next request at flush_pc.
